// File: rtl/shift_xfer_ctrl.sv
// Full-duplex word exchange sequencer driving an external 4-function shift register.
// Loads a word, issues WIDTH shift pulses every DIV cycles, then presents the received word.
module shift_xfer_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  input  logic [WIDTH-1:0] tx_word_i,
  input  logic             dir_i,
  input  logic             sdi_i,
  output logic             sdo_o,
  output logic             busy_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic [WIDTH-1:0] rx_word_o,
  output logic [1:0]       sr_funct_o,
  output logic [WIDTH-1:0] sr_word_o,
  output logic             sr_serial_o,
  input  logic [WIDTH-1:0] sr_q_i
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_RELOAD = DW'(DIV - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(WIDTH - 1);

  localparam logic [1:0] FN_NA    = 2'b00;
  localparam logic [1:0] FN_LOAD  = 2'b01;
  localparam logic [1:0] FN_LEFT  = 2'b10;
  localparam logic [1:0] FN_RIGHT = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] word_q;
  logic             dir_q;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic [BW-1:0]    bit_cnt_q;
  logic             pulse_q;
  logic             busy_q;
  logic [1:0]       funct_q;
  logic             rx_valid_q;
  logic [WIDTH-1:0] rx_word_q;
  logic [1:0]       shift_fn;
  logic             last_pulse;
  logic             pulse_d;

  assign shift_fn   = dir_q ? FN_RIGHT : FN_LEFT;
  assign div_cnt_d  = (div_cnt_q == '0) ? DIV_RELOAD : div_cnt_q - 1'b1;
  assign last_pulse = pulse_q && (bit_cnt_q == LAST_BIT);
  // pulse_q/funct_q are computed one cycle ahead so the funct code comes straight from flops
  assign pulse_d    = (div_cnt_d == '0) && !last_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      dir_q      <= 1'b0;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
      funct_q    <= FN_NA;
      rx_valid_q <= 1'b0;
      rx_word_q  <= '0;
    end else begin
      if (rx_valid_q && rx_ready_i) rx_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tx_valid_i && tx_ready_o) begin
            word_q  <= tx_word_i;
            dir_q   <= dir_i;
            busy_q  <= 1'b1;
            funct_q <= FN_LOAD;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          div_cnt_q <= DIV_RELOAD;
          bit_cnt_q <= '0;
          pulse_q   <= (DIV == 1);
          funct_q   <= (DIV == 1) ? shift_fn : FN_NA;
          state_q   <= S_SHIFT;
        end
        S_SHIFT: begin
          div_cnt_q <= div_cnt_d;
          pulse_q   <= pulse_d;
          funct_q   <= pulse_d ? shift_fn : FN_NA;
          if (pulse_q) bit_cnt_q <= bit_cnt_q + 1'b1;
          if (last_pulse) begin
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          rx_word_q  <= sr_q_i;
          rx_valid_q <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_ready_o  = (state_q == S_IDLE) && !rx_valid_q;
  assign busy_o      = busy_q;
  assign rx_valid_o  = rx_valid_q;
  assign rx_word_o   = rx_word_q;
  assign sr_funct_o  = funct_q;
  assign sr_word_o   = word_q;
  assign sr_serial_o = pulse_q & sdi_i;
  assign sdo_o       = (state_q == S_SHIFT) ? (dir_q ? sr_q_i[0] : sr_q_i[WIDTH-1]) : 1'b0;

endmodule

// File: tb/tb_shift_xfer_ctrl.sv
// Bench for shift_xfer_ctrl: two instances (DIV=1, DIV=3) each wired to a behavioural shift register.
module tb_shift_xfer_ctrl;

  localparam int W = 4;
  localparam logic [1:0] FN_NA = 2'b00, FN_LOAD = 2'b01, FN_LEFT = 2'b10, FN_RIGHT = 2'b11;

  logic             clk;
  logic [1:0]       rst_n, tx_valid, dir, sdi, rx_ready;
  logic [1:0]       tx_ready, sdo, busy, rx_valid, sr_serial;
  logic [W-1:0]     tx_word [2];
  logic [W-1:0]     rx_word [2];
  logic [W-1:0]     sr_word [2];
  logic [1:0]       sr_funct [2];
  logic [W-1:0]     srq0, srq1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_xfer_ctrl #(.WIDTH(W), .DIV(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .tx_valid_i(tx_valid[0]), .tx_ready_o(tx_ready[0]),
    .tx_word_i(tx_word[0]), .dir_i(dir[0]), .sdi_i(sdi[0]), .sdo_o(sdo[0]), .busy_o(busy[0]),
    .rx_valid_o(rx_valid[0]), .rx_ready_i(rx_ready[0]), .rx_word_o(rx_word[0]),
    .sr_funct_o(sr_funct[0]), .sr_word_o(sr_word[0]), .sr_serial_o(sr_serial[0]), .sr_q_i(srq0)
  );

  shift_xfer_ctrl #(.WIDTH(W), .DIV(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .tx_valid_i(tx_valid[1]), .tx_ready_o(tx_ready[1]),
    .tx_word_i(tx_word[1]), .dir_i(dir[1]), .sdi_i(sdi[1]), .sdo_o(sdo[1]), .busy_o(busy[1]),
    .rx_valid_o(rx_valid[1]), .rx_ready_i(rx_ready[1]), .rx_word_o(rx_word[1]),
    .sr_funct_o(sr_funct[1]), .sr_word_o(sr_word[1]), .sr_serial_o(sr_serial[1]), .sr_q_i(srq1)
  );

  // The external 4-function shift register each controller drives
  always_ff @(posedge clk or negedge rst_n[0]) begin
    if (!rst_n[0]) srq0 <= '0;
    else case (sr_funct[0])
      FN_LOAD:  srq0 <= sr_word[0];
      FN_LEFT:  srq0 <= {srq0[W-2:0], sr_serial[0]};
      FN_RIGHT: srq0 <= {sr_serial[0], srq0[W-1:1]};
      default:  srq0 <= srq0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n[1]) begin
    if (!rst_n[1]) srq1 <= '0;
    else case (sr_funct[1])
      FN_LOAD:  srq1 <= sr_word[1];
      FN_LEFT:  srq1 <= {srq1[W-2:0], sr_serial[1]};
      FN_RIGHT: srq1 <= {sr_serial[1], srq1[W-1:1]};
      default:  srq1 <= srq1;
    endcase
  end

  function automatic int div_of(input int inst);
    return (inst == 0) ? 1 : 3;
  endfunction

  // Word-level exchange: bit k of s is what arrives on sdi with pulse k+1
  function automatic logic [W-1:0] ref_rx(input logic d, input logic [W-1:0] s);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < W; k++) begin
      if (d) r[k] = s[k];
      else   r[W-1-k] = s[k];
    end
    return r;
  endfunction

  function automatic logic ref_sdo(input logic [W-1:0] word, input logic d, input int k);
    return d ? word[k] : word[W-1-k];
  endfunction

  task automatic tx_offer(input int inst, input logic [W-1:0] word, input logic d, output int acc);
    acc = -1;
    @(posedge clk); #1;
    tx_valid[inst] = 1'b1;
    tx_word[inst]  = word;
    dir[inst]      = d;
    for (int i = 0; i < 40 && acc < 0; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      if (tx_ready[inst] === 1'b1) acc = cyc;
    end
    checks++;
    if (acc < 0) begin
      errors++;
      $display("FAIL tx_accept[%0d]: got no handshake within 40 cycles, expected one", inst);
    end
  endtask

  // Runs cycles 1..rx_valid after a tx handshake at cycle 0, checking every cycle
  task automatic xfer_body(input int inst, input logic [W-1:0] word, input logic d,
                           input logic [W-1:0] s, output int rise);
    int dv, n_last, n_end, k;
    logic pulse, es;
    logic [1:0] ef;
    dv = div_of(inst);
    n_last = 1 + W * dv;
    n_end = n_last + 2;
    rise = -1;
    for (int t = 1; t <= n_end; t++) begin
      @(posedge clk); #1;
      if (t == 1) begin
        tx_valid[inst] = 1'b0;
        tx_word[inst]  = 4'($urandom);
        dir[inst]      = 1'($urandom);
      end
      pulse = (t > 1) && (t <= n_last) && (((t - 1) % dv) == 0);
      k = pulse ? ((t - 1) / dv - 1) : 0;
      es = pulse ? s[k] : 1'b0;
      sdi[inst] = pulse ? s[k] : 1'($urandom);
      @(negedge clk);
      ef = (t == 1) ? FN_LOAD : (pulse ? (d ? FN_RIGHT : FN_LEFT) : FN_NA);
      checks++;
      if (sr_funct[inst] !== ef) begin
        errors++; $display("FAIL funct[%0d] t=%0d: got %0d, expected %0d", inst, t, sr_funct[inst], ef);
      end
      checks++;
      if (busy[inst] !== 1'(t <= n_last)) begin
        errors++; $display("FAIL busy[%0d] t=%0d: got %0b, expected %0b", inst, t, busy[inst], t <= n_last);
      end
      checks++;
      if (tx_ready[inst] !== 1'b0) begin
        errors++; $display("FAIL tx_ready[%0d] t=%0d: got %0b, expected 0", inst, t, tx_ready[inst]);
      end
      checks++;
      if (rx_valid[inst] !== 1'(t == n_end)) begin
        errors++; $display("FAIL rx_valid[%0d] t=%0d: got %0b, expected %0b", inst, t, rx_valid[inst], t == n_end);
      end
      checks++;
      if (sr_serial[inst] !== es) begin
        errors++; $display("FAIL sr_serial[%0d] t=%0d: got %0b, expected %0b", inst, t, sr_serial[inst], es);
      end
      if (pulse) begin
        checks++;
        if (sdo[inst] !== ref_sdo(word, d, k)) begin
          errors++; $display("FAIL sdo[%0d] t=%0d: got %0b, expected %0b", inst, t, sdo[inst], ref_sdo(word, d, k));
        end
      end else if (t == 1 || t > n_last) begin
        checks++;
        if (sdo[inst] !== 1'b0) begin
          errors++; $display("FAIL sdo_idle[%0d] t=%0d: got %0b, expected 0", inst, t, sdo[inst]);
        end
      end
      if (t == 1) begin
        checks++;
        if (sr_word[inst] !== word) begin
          errors++; $display("FAIL sr_word[%0d]: got %0h, expected %0h", inst, sr_word[inst], word);
        end
      end
      if (t == n_end) begin
        rise = cyc;
        checks++;
        if (rx_word[inst] !== ref_rx(d, s)) begin
          errors++; $display("FAIL rx_word[%0d]: got %0h, expected %0h", inst, rx_word[inst], ref_rx(d, s));
        end
      end
    end
  endtask

  task automatic do_xfer(input int inst, input logic [W-1:0] word, input logic d,
                         input logic [W-1:0] s, output int rise);
    int acc;
    tx_offer(inst, word, d, acc);
    rise = -1;
    if (acc >= 0) xfer_body(inst, word, d, s, rise);
  endtask

  task automatic test_reset;
    rst_n = 2'b00; tx_valid = 2'b00; dir = 2'b00; sdi = 2'b00; rx_ready = 2'b11;
    tx_word[0] = 4'h9; tx_word[1] = 4'h6;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({tx_ready[i], sdo[i], busy[i], rx_valid[i], sr_serial[i]} !== 5'b10000) begin
        errors++; $display("FAIL reset_ctl[%0d]: got %05b, expected 10000", i,
                           {tx_ready[i], sdo[i], busy[i], rx_valid[i], sr_serial[i]});
      end
      checks++;
      if ({rx_word[i], sr_word[i], sr_funct[i]} !== '0) begin
        errors++; $display("FAIL reset_data[%0d]: got %0h, expected 0", i, {rx_word[i], sr_word[i], sr_funct[i]});
      end
    end
    @(posedge clk); #1;
    rst_n = 2'b11;
  endtask

  task automatic test_left;
    int r;
    do_xfer(0, 4'b1011, 1'b0, 4'b0110, r);
  endtask

  task automatic test_right;
    int r;
    do_xfer(0, 4'b1011, 1'b1, 4'b0001, r);
  endtask

  task automatic test_div3;
    int r;
    do_xfer(1, 4'($urandom), 1'($urandom), 4'($urandom), r);
    do_xfer(1, 4'($urandom), 1'($urandom), 4'($urandom), r);
  endtask

  task automatic test_random;
    int r;
    for (int n = 0; n < 6; n++) begin
      do_xfer(0, 4'($urandom), 1'($urandom), 4'($urandom), r);
      do_xfer(1, 4'($urandom), 1'($urandom), 4'($urandom), r);
    end
  endtask

  task automatic test_hold;
    int r;
    logic [W-1:0] held, s2;
    logic d2;
    rx_ready[0] = 1'b0;
    do_xfer(0, 4'($urandom), 1'($urandom), 4'($urandom), r);
    held = rx_word[0];
    d2 = 1'($urandom);
    s2 = 4'($urandom);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tx_valid[0] = 1'b1; tx_word[0] = 4'hF; dir[0] = d2;
      @(negedge clk);
      checks++;
      if ({rx_valid[0], tx_ready[0], busy[0], sr_funct[0], rx_word[0]} !== {1'b1, 1'b0, 1'b0, FN_NA, held}) begin
        errors++; $display("FAIL hold i=%0d: got v=%0b rdy=%0b busy=%0b fn=%0d w=%0h, expected 1 0 0 0 %0h", i,
                           rx_valid[0], tx_ready[0], busy[0], sr_funct[0], rx_word[0], held);
      end
    end
    @(posedge clk); #1;
    rx_ready[0] = 1'b1;
    @(negedge clk);
    checks++;
    if ({rx_valid[0], tx_ready[0]} !== 2'b10) begin
      errors++; $display("FAIL rx_hs_cycle: got v=%0b rdy=%0b, expected 1 0", rx_valid[0], tx_ready[0]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({rx_valid[0], tx_ready[0]} !== 2'b01) begin
      errors++; $display("FAIL after_rx_hs: got v=%0b rdy=%0b, expected 0 1", rx_valid[0], tx_ready[0]);
    end
    xfer_body(0, 4'hF, d2, s2, r);
  endtask

  task automatic test_reset_mid;
    int acc, seen;
    rx_ready[0] = 1'b1;
    tx_offer(0, 4'b1011, 1'b0, acc);
    for (int t = 1; t <= 3; t++) begin
      @(posedge clk); #1;
      if (t == 1) tx_valid[0] = 1'b0;
      sdi[0] = 1'($urandom);
    end
    #2;
    rst_n[0] = 1'b0;
    #1;
    checks++;
    if ({sr_funct[0], busy[0], tx_ready[0], sdo[0], rx_valid[0], sr_serial[0]} !== {FN_NA, 5'b01000}) begin
      errors++; $display("FAIL async_reset: got fn=%0d busy=%0b rdy=%0b sdo=%0b v=%0b ser=%0b, expected 0 0 1 0 0 0",
                         sr_funct[0], busy[0], tx_ready[0], sdo[0], rx_valid[0], sr_serial[0]);
    end
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rx_valid[0] !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL no_rx_after_reset: got %0d cycles with rx_valid, expected 0", seen);
    end
    test_left();
  endtask

  task automatic test_back_to_back;
    int r1, r2, acc;
    logic [W-1:0] w2, s2;
    logic d2;
    rx_ready = 2'b11;
    for (int inst = 0; inst < 2; inst++) begin
      do_xfer(inst, 4'($urandom), 1'($urandom), 4'($urandom), r1);
      w2 = 4'($urandom); d2 = 1'($urandom); s2 = 4'($urandom);
      tx_offer(inst, w2, d2, acc);
      checks++;
      if (acc - r1 != 1) begin
        errors++; $display("FAIL b2b_accept[%0d]: got %0d cycles after rx_valid, expected 1", inst, acc - r1);
      end
      if (acc >= 0) xfer_body(inst, w2, d2, s2, r2);
    end
  endtask

  initial begin
    test_reset();
    test_left();
    test_right();
    test_div3();
    test_random();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
